// File: rtl/md_unit_pkg.sv
// Shared multiply/divide constants: operation encodings, default latencies, FSM states.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  localparam int unsigned MD_MULT_CYCLES = 5;
  localparam int unsigned MD_DIV_CYCLES  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_unit.sv
// HI/LO multiply-divide unit. The result is computed at start into shadow
// registers and committed to HI/LO on the last busy cycle, so the pipeline
// sees a fixed multi-cycle latency while old HI/LO stay readable.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] hi_sh_q, hi_sh_d, lo_sh_q, lo_sh_d;

  logic        [63:0] a_s64, b_s64, prod_s, prod_u, div_b_u;
  logic signed [63:0] div_b_s;
  logic        [31:0] quot_s, rem_s, quot_u, rem_u;
  logic               div_zero;

  // Datapath: 64-bit products and quotients; a zero divisor is replaced by 1
  // so the divider never produces X (the result is discarded anyway).
  always_comb begin
    div_zero = (rt_val == 32'd0);
    a_s64    = {{32{rs_val[31]}}, rs_val};
    b_s64    = {{32{rt_val[31]}}, rt_val};
    prod_s   = a_s64 * b_s64;
    prod_u   = {32'd0, rs_val} * {32'd0, rt_val};
    div_b_s  = div_zero ? 64'sd1 : $signed(b_s64);
    div_b_u  = div_zero ? 64'd1 : {32'd0, rt_val};
    // Sign-extending to 64 bits makes 0x80000000 / -1 land on 0x80000000, rem 0.
    quot_s   = 32'($signed(a_s64) / div_b_s);
    rem_s    = 32'($signed(a_s64) % div_b_s);
    quot_u   = 32'({32'd0, rs_val} / div_b_u);
    rem_u    = 32'({32'd0, rs_val} % div_b_u);
  end

  // Next-state: accept work in IDLE, count down in RUN, commit on the last cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_sh_d = hi_sh_q;
    lo_sh_d = lo_sh_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (md_op_e'(md_op))
            MD_MULT: begin
              {hi_sh_d, lo_sh_d} = prod_s;
              cnt_d   = MULT_LAT;
              state_d = ST_RUN;
            end
            MD_MULTU: begin
              {hi_sh_d, lo_sh_d} = prod_u;
              cnt_d   = MULT_LAT;
              state_d = ST_RUN;
            end
            MD_DIV, MD_DIVU: begin
              // Divide by zero: shadow holds current HI/LO so the commit is a no-op.
              if (div_zero) begin
                hi_sh_d = hi_q;
                lo_sh_d = lo_q;
              end else if (md_op_e'(md_op) == MD_DIV) begin
                hi_sh_d = rem_s;
                lo_sh_d = quot_s;
              end else begin
                hi_sh_d = rem_u;
                lo_sh_d = quot_u;
              end
              cnt_d   = DIV_LAT;
              state_d = ST_RUN;
            end
            MD_MTHI: hi_d = rs_val;
            MD_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (cnt_q == 4'd1) begin
          hi_d    = hi_sh_q;
          lo_d    = lo_sh_q;
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset wins over any start and drops in-flight results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      hi_sh_q <= 32'd0;
      lo_sh_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_sh_q <= hi_sh_d;
      lo_sh_q <= lo_sh_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule
